// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with shadowed config
//
// Purpose:
//   CHANNELS independent divider channels. Each channel has a counter that
//   runs from 0 up to a terminal count P, giving a period of P+1 cycles. The
//   channel output is high for the first H cycles of each period. A tick
//   pulses in the first cycle of each period.
//   Period and high time are written into a per-channel shadow and copied to
//   the active settings only at a period boundary, or on the next edge while
//   the channel is disabled, so a running waveform never shows a runt period.
//   A global sync strobe forces every enabled channel to restart its period.
//
// Optional feature (define CLK_DIV_MULTI_POLARITY_EN):
//   Adds input cfg_inv, shadowed and applied together with period/high.
//   A channel whose active inv bit is set drives an inverted clk_out while
//   running and idles at 1 while disabled. tick is unaffected.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ch_en        per-channel run enable (level)
//   sync         one-cycle strobe; every enabled channel wraps on this edge
//   cfg_wr       config write strobe
//   cfg_ch       target channel of the write; values >= CHANNELS are ignored
//   cfg_period   terminal count P (period is P+1 cycles)
//   cfg_high     high time H in cycles
//   cfg_inv      (optional) output polarity for the target channel
//   cfg_pending  per channel: shadow written but not yet applied
//   clk_out      divided waveform, registered
//   tick         one-cycle pulse in the first cycle of each period, registered

module clk_div_multi #(
  parameter int unsigned       WIDTH          = 24,
  parameter int unsigned       CHANNELS       = 4,
  parameter int unsigned       CH_W           = 2,
  parameter logic [WIDTH-1:0]  DEFAULT_PERIOD = 24'd15999999,
  parameter logic [WIDTH-1:0]  DEFAULT_HIGH   = 24'd8000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_high,
`ifdef CLK_DIV_MULTI_POLARITY_EN
  input  logic                cfg_inv,
`endif
  output logic [CHANNELS-1:0] cfg_pending,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    // Registered channel state
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] act_high;
    logic [WIDTH-1:0] shd_period;
    logic [WIDTH-1:0] shd_high;
    logic             pending;
    logic             out_q;
    logic             tick_q;

    // Next-state values
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] act_period_nxt;
    logic [WIDTH-1:0] act_high_nxt;
    logic             pending_nxt;
    logic             out_nxt;
    logic             tick_nxt;

    logic             sel;
    logic             wrap;
    logic             apply;
    logic             high_phase;

`ifdef CLK_DIV_MULTI_POLARITY_EN
    logic             act_inv;
    logic             shd_inv;
    logic             act_inv_nxt;
`endif

    // cfg_ch values at or above CHANNELS match no channel, so such writes
    // are dropped without extra logic.
    assign sel   = cfg_wr && (cfg_ch == CH_W'(i));

    // sync landing on the terminal count is still just one wrap.
    assign wrap  = ch_en[i] && (sync || (cnt == act_period));

    // A disabled channel has no waveform to protect, so a pending shadow is
    // taken on the very next edge; a running one waits for its wrap.
    assign apply = pending && (wrap || !ch_en[i]);

    always_comb begin
      act_period_nxt = apply ? shd_period : act_period;
      act_high_nxt   = apply ? shd_high   : act_high;

      // Holding a disabled counter at its terminal count makes the first
      // enabled edge a wrap, so the channel starts with a full period.
      if (!ch_en[i]) begin
        cnt_nxt = act_period_nxt;
      end else if (wrap) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end

      // A write on the wrap edge is not consumed by that wrap: apply uses
      // the old shadow and the new write stays pending.
      if (sel) begin
        pending_nxt = 1'b1;
      end else if (apply) begin
        pending_nxt = 1'b0;
      end else begin
        pending_nxt = pending;
      end
    end

    // Outputs are computed from the post-edge counter and settings so that
    // they line up with the cycle the counter is in.
    assign high_phase = cnt_nxt < act_high_nxt;
    assign tick_nxt   = ch_en[i] && (cnt_nxt == '0);

`ifdef CLK_DIV_MULTI_POLARITY_EN
    assign act_inv_nxt = apply ? shd_inv : act_inv;
    assign out_nxt     = ch_en[i] ? (high_phase ^ act_inv_nxt) : act_inv_nxt;
`else
    assign out_nxt     = ch_en[i] && high_phase;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt        <= DEFAULT_PERIOD;
        act_period <= DEFAULT_PERIOD;
        act_high   <= DEFAULT_HIGH;
        shd_period <= DEFAULT_PERIOD;
        shd_high   <= DEFAULT_HIGH;
        pending    <= 1'b0;
        out_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt        <= cnt_nxt;
        act_period <= act_period_nxt;
        act_high   <= act_high_nxt;
        pending    <= pending_nxt;
        out_q      <= out_nxt;
        tick_q     <= tick_nxt;
        if (sel) begin
          shd_period <= cfg_period;
          shd_high   <= cfg_high;
        end
      end
    end

`ifdef CLK_DIV_MULTI_POLARITY_EN
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        act_inv <= 1'b0;
        shd_inv <= 1'b0;
      end else begin
        act_inv <= act_inv_nxt;
        if (sel) begin
          shd_inv <= cfg_inv;
        end
      end
    end
`endif

    assign cfg_pending[i] = pending;
    assign clk_out[i]     = out_q;
    assign tick[i]        = tick_q;

  end : g_ch

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi (WIDTH=8, P=9, H=5 defaults)

module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ch_en = 4'h0;
  logic       sync = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_period = 8'd0;
  logic [7:0] cfg_high = 8'd0;
  logic [3:0] cfg_pending;
  logic [3:0] clk_out;
  logic [3:0] tick;

  clk_div_multi #(
    .WIDTH(8),
    .CHANNELS(4),
    .CH_W(2),
    .DEFAULT_PERIOD(8'd9),
    .DEFAULT_HIGH(8'd5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ch_en(ch_en),
    .sync(sync),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
`ifdef CLK_DIV_MULTI_POLARITY_EN
    .cfg_inv(1'b0),
`endif
    .cfg_pending(cfg_pending),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] clk_e;
    logic [3:0] tck_e;
    logic [3:0] pnd_e;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Directed expectation state: for each channel the edge at which its
  // current (P, H) segment started; the waveform is read off from there.
  int         e = 0;
  bit         in_rst = 1'b1;
  bit         en_b[4];
  int         st_b[4];
  int         p_b[4];
  int         h_b[4];
  logic [3:0] pend_b = 4'h0;

  task automatic push_exp(input string name);
    exp_t x;
    x.name  = name;
    x.clk_e = 4'h0;
    x.tck_e = 4'h0;
    x.pnd_e = 4'h0;
    if (!in_rst) begin
      x.pnd_e = pend_b;
      for (int i = 0; i < 4; i++) begin
        if (en_b[i]) begin
          int pos;
          pos        = (e - st_b[i]) % (p_b[i] + 1);
          x.clk_e[i] = (pos < h_b[i]);
          x.tck_e[i] = (pos == 0);
        end
      end
    end
    q.push_back(x);
  endtask

  task automatic edge_chk(input string name);
    @(posedge clk);
    #1;
    e++;
    push_exp(name);
  endtask

  task automatic run(input int n, input string name);
    for (int k = 0; k < n; k++) edge_chk(name);
  endtask

  // Segment begins on the coming edge.
  task automatic seg(input int i, input int p, input int h);
    en_b[i] = 1'b1;
    st_b[i] = e + 1;
    p_b[i]  = p;
    h_b[i]  = h;
  endtask

  task automatic wr(input int ch, input int p, input int h);
    cfg_wr     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = 8'(p);
    cfg_high   = 8'(h);
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compares every queued expectation against the outputs half a
  // cycle after the edge that produced them.
  exp_t mx;
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        mx = q.pop_front();
        check4({mx.name, ".clk_out"},     clk_out,     mx.clk_e);
        check4({mx.name, ".tick"},        tick,        mx.tck_e);
        check4({mx.name, ".cfg_pending"}, cfg_pending, mx.pnd_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      en_b[i] = 1'b0; st_b[i] = 0; p_b[i] = 9; h_b[i] = 5;
    end

    // Reset held with activity on the inputs: everything must stay 0.
    ch_en = 4'hF;
    wr(2, 3, 1);
    run(3, "reset");

    // Single channel at defaults: 5 high / 5 low, tick on first edge.
    reset  = 1'b0;
    in_rst = 1'b0;
    cfg_wr = 1'b0;
    ch_en  = 4'b0001;
    seg(0, 9, 5);
    run(25, "p1_default");

    // Ch1 reprogrammed mid-period at cnt=4.
    ch_en = 4'b0011;
    seg(1, 9, 5);
    run(5, "p2_pre");
    wr(1, 3, 1);
    pend_b[1] = 1'b1;
    edge_chk("p2_wr");
    cfg_wr = 1'b0;
    run(4, "p2_pending");
    seg(1, 3, 1);
    pend_b[1] = 1'b0;
    edge_chk("p2_apply");
    run(8, "p2_new");

    // Write landing on a ch0 wrap edge stays pending for a full period.
    while (((e + 1 - st_b[0]) % 10) != 0) edge_chk("p3_align");
    wr(0, 5, 2);
    pend_b[0] = 1'b1;
    edge_chk("p3_wrap_wr");
    cfg_wr = 1'b0;
    run(9, "p3_old");
    seg(0, 5, 2);
    pend_b[0] = 1'b0;
    edge_chk("p3_apply");
    run(1, "p3_new");
    // Two writes within one period: the later one wins.
    wr(0, 2, 9);
    pend_b[0] = 1'b1;
    edge_chk("p3_wr_a");
    wr(0, 4, 1);
    edge_chk("p3_wr_b");
    cfg_wr = 1'b0;
    run(2, "p3_wait");
    seg(0, 4, 1);
    pend_b[0] = 1'b0;
    edge_chk("p3_lastwin");
    run(12, "p3_run");

    // Boundary settings written while disabled (applied on the next edge).
    ch_en   = 4'b0001;
    en_b[1] = 1'b0;
    edge_chk("p4_dis");
    wr(1, 9, 0);
    pend_b[1] = 1'b1;
    edge_chk("p4_wr1");
    wr(2, 9, 12);
    pend_b = 4'b0100;
    edge_chk("p4_wr2");
    wr(3, 0, 1);
    pend_b = 4'b1000;
    edge_chk("p4_wr3");
    cfg_wr = 1'b0;
    pend_b = 4'b0000;
    edge_chk("p4_idle");
    ch_en = 4'b1111;
    seg(1, 9, 0);
    seg(2, 9, 12);
    seg(3, 0, 1);
    run(25, "p4_edge_cases");

    // Sync with one channel disabled.
    ch_en   = 4'b1011;
    en_b[2] = 1'b0;
    run(3, "p5_pre");
    sync = 1'b1;
    seg(0, 4, 1);
    seg(1, 9, 0);
    seg(3, 0, 1);
    edge_chk("p5_sync");
    sync = 1'b0;
    run(12, "p5_post");

    // Asynchronous reset mid-period with a pending write.
    wr(1, 3, 2);
    pend_b[1] = 1'b1;
    edge_chk("p6_wr");
    cfg_wr = 1'b0;
    @(negedge clk);
    #1;
    reset  = 1'b1;
    in_rst = 1'b1;
    #1;
    push_exp("p6_async");
    run(2, "p6_hold");
    reset  = 1'b0;
    in_rst = 1'b0;
    ch_en  = 4'b0011;
    pend_b = 4'h0;
    for (int i = 0; i < 4; i++) en_b[i] = 1'b0;
    seg(0, 9, 5);
    seg(1, 9, 5);
    run(22, "p6_defaults");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
